// File: rtl/router_pkg.sv
// Shared definitions for the router output demux: port count, header field layout, FSM states.
package router_pkg;
    localparam int NUM_PORTS = 3;
    localparam int DATA_W    = 32;

    // Header word layout: [1:0] destination port, [7:2] payload length in words.
    localparam int DEST_LSB = 0;
    localparam int DEST_W   = 2;
    localparam int LEN_LSB  = 2;
    localparam int LEN_W    = 6;

    localparam logic [DEST_W-1:0] DEST_DROP = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PAYLOAD,
        ST_DROP
    } state_t;
endpackage

// File: rtl/router_port_fifo.sv
// Show-ahead per-port FIFO; written word is visible on rd_data the next cycle.
// Writes are ignored when full; flush empties it and overrides any same-cycle read or write.
module router_port_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    input  logic             flush,
    output logic [WIDTH-1:0] rd_data,
    output logic             empty,
    output logic             full
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_wr;
    logic             do_rd;

    assign empty   = (count == '0);
    assign full    = (count == FULL_CNT);
    assign do_wr   = wr_en && !full && !flush;
    assign do_rd   = rd_en && !empty && !flush;
    // Empty FIFO presents zero so out_data is clean after reset and flush.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            if (do_wr && !do_rd)      count <= count + 1'b1;
            else if (!do_wr && do_rd) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end
endmodule

// File: rtl/router_out_demux.sv
// Routes header+payload packets to one of three output FIFOs, dropping dest-3 packets; one-cycle latency.
// in_ready follows target-FIFO space (any-full in IDLE); stalled ports are flushed after TIMEOUT cycles.
module router_out_demux
    import router_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 30
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [DATA_W-1:0]           in_data,
    input  logic                        in_valid,
    output logic                        in_ready,
    output logic [NUM_PORTS*DATA_W-1:0] out_data,
    output logic [NUM_PORTS-1:0]        out_valid,
    input  logic [NUM_PORTS-1:0]        out_ready,
    output logic [NUM_PORTS-1:0]        timeout_pulse,
    output logic                        busy,
    output logic [7:0]                  drop_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);

    state_t              state;
    state_t              state_nxt;
    logic [LEN_W-1:0]    rem;
    logic [LEN_W-1:0]    rem_nxt;
    logic [DEST_W-1:0]   tgt;
    logic [DEST_W-1:0]   tgt_nxt;
    logic [DEST_W-1:0]   hdr_dest;
    logic [LEN_W-1:0]    hdr_len;
    logic [NUM_PORTS-1:0] full;
    logic [NUM_PORTS-1:0] empty;
    logic [NUM_PORTS-1:0] flush;
    logic [NUM_PORTS-1:0] wr_sel;
    logic                accept;
    logic                drop_hdr;

    assign hdr_dest = in_data[DEST_LSB +: DEST_W];
    assign hdr_len  = in_data[LEN_LSB +: LEN_W];

    always_comb begin
        in_ready = 1'b0;
        if (!rst) begin
            case (state)
                ST_IDLE:    in_ready = ~|full;
                ST_PAYLOAD: in_ready = !full[tgt];
                ST_DROP:    in_ready = 1'b1;
                default:    in_ready = 1'b0;
            endcase
        end
    end

    assign accept = in_valid && in_ready;

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        tgt_nxt   = tgt;
        wr_sel    = '0;
        drop_hdr  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    if (hdr_dest == DEST_DROP) begin
                        drop_hdr = 1'b1;
                        if (hdr_len != '0) begin
                            state_nxt = ST_DROP;
                            rem_nxt   = hdr_len;
                        end
                    end else begin
                        tgt_nxt = hdr_dest;
                        for (int p = 0; p < NUM_PORTS; p++) wr_sel[p] = (hdr_dest == DEST_W'(p));
                        if (hdr_len != '0) begin
                            rem_nxt = hdr_len;
                            // A flush racing the header discards the whole packet.
                            state_nxt = (|(flush & wr_sel)) ? ST_DROP : ST_PAYLOAD;
                        end
                    end
                end
            end
            ST_PAYLOAD: begin
                if (accept) begin
                    for (int p = 0; p < NUM_PORTS; p++) wr_sel[p] = (tgt == DEST_W'(p));
                    rem_nxt = rem - 1'b1;
                end
                if (accept && rem == LEN_W'(1)) state_nxt = ST_IDLE;
                else if (flush[tgt])            state_nxt = ST_DROP;
            end
            ST_DROP: begin
                if (accept) begin
                    rem_nxt = rem - 1'b1;
                    if (rem == LEN_W'(1)) state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            rem      <= '0;
            tgt      <= '0;
            drop_cnt <= '0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
            tgt   <= tgt_nxt;
            if (drop_hdr && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
        end
    end

    assign busy = (state == ST_PAYLOAD) || (state == ST_DROP);

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic [TW-1:0] timer;
        logic          stall;

        router_port_fifo #(
            .DEPTH (DEPTH),
            .WIDTH (DATA_W)
        ) u_fifo (
            .clk     (clk),
            .rst     (rst),
            .wr_en   (wr_sel[p]),
            .wr_data (in_data),
            .rd_en   (out_ready[p]),
            .flush   (flush[p]),
            .rd_data (out_data[p*DATA_W +: DATA_W]),
            .empty   (empty[p]),
            .full    (full[p])
        );

        assign out_valid[p] = !empty[p];
        assign stall        = out_valid[p] && !out_ready[p];
        // Flush fires during the TIMEOUT-th consecutive stalled cycle.
        assign flush[p]     = stall && (timer == TW'(TIMEOUT - 1));

        always_ff @(posedge clk or posedge rst) begin
            if (rst)                    timer <= '0;
            else if (!stall || flush[p]) timer <= '0;
            else                        timer <= timer + 1'b1;
        end
    end

    assign timeout_pulse = flush;
endmodule

// File: tb/tb_router_out_demux.sv
// Scoreboard bench for router_out_demux: routing, drop, backpressure, timeout flush and reset.
module tb_router_out_demux;
    logic        clk;
    logic        rst;
    logic [31:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [95:0] out_data;
    logic [2:0]  out_valid;
    logic [2:0]  out_ready;
    logic [2:0]  timeout_pulse;
    logic        busy;
    logic [7:0]  drop_cnt;

    int errors = 0;
    int checks = 0;
    int busy_cnt = 0;
    int rdy_low_cnt = 0;
    logic [31:0] sb0[$];
    logic [31:0] sb1[$];
    logic [31:0] sb2[$];
    logic        s_rdy;
    logic        s_busy;
    logic        acc;
    logic [2:0]  s_valid;
    logic [2:0]  s_pulse;

    router_out_demux #(.DEPTH(4), .TIMEOUT(30)) dut (
        .clk           (clk),
        .rst           (rst),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .out_data      (out_data),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .timeout_pulse (timeout_pulse),
        .busy          (busy),
        .drop_cnt      (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic push(input int p, input logic [31:0] w);
        case (p)
            0: sb0.push_back(w);
            1: sb1.push_back(w);
            default: sb2.push_back(w);
        endcase
    endtask

    // One clock: sample at negedge, retire delivered words against the scoreboard, return at posedge+1.
    task automatic cycle();
        @(negedge clk);
        s_rdy   = in_ready;
        s_busy  = busy;
        s_valid = out_valid;
        s_pulse = timeout_pulse;
        acc     = in_valid && in_ready;
        if (busy) busy_cnt++;
        if (!in_ready) rdy_low_cnt++;
        for (int p = 0; p < 3; p++) begin
            if (out_valid[p] && out_ready[p]) begin
                logic [31:0] exp_w;
                logic [31:0] got_w;
                bit have;
                have  = 1'b0;
                exp_w = '0;
                got_w = out_data[32*p +: 32];
                case (p)
                    0: if (sb0.size() > 0) begin exp_w = sb0.pop_front(); have = 1'b1; end
                    1: if (sb1.size() > 0) begin exp_w = sb1.pop_front(); have = 1'b1; end
                    default: if (sb2.size() > 0) begin exp_w = sb2.pop_front(); have = 1'b1; end
                endcase
                checks++;
                if (!have) begin
                    errors++;
                    $display("FAIL sb_port%0d: unexpected word %h, expected no output", p, got_w);
                end else if (got_w !== exp_w) begin
                    errors++;
                    $display("FAIL sb_port%0d: got %h, want %h", p, got_w, exp_w);
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int n);
        repeat (n) cycle();
    endtask

    task automatic send_word(input logic [31:0] w);
        bit got;
        got      = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 100 && !got; i++) begin
            cycle();
            got = acc;
        end
        in_valid = 1'b0;
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL send_word: %h accepted=0 after 100 cycles, want 1", w);
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 3'b000)   begin errors++; $display("FAIL rst_out_valid: got %b want 000", out_valid); end
        checks++; if (out_data !== 96'd0)     begin errors++; $display("FAIL rst_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'd0)      begin errors++; $display("FAIL rst_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (timeout_pulse !== 3'b0) begin errors++; $display("FAIL rst_pulse: got %b want 000", timeout_pulse); end
        rst = 1'b0;
        cycle();
        checks++; if (s_rdy !== 1'b1) begin errors++; $display("FAIL rst_release_ready: got %b want 1", s_rdy); end
    endtask

    task automatic test_route();
        int b0;
        logic [31:0] pkt [4];
        pkt = '{32'h0000_000D, 32'h1111_0001, 32'h1111_0002, 32'h1111_0003};
        out_ready = 3'b111;
        foreach (pkt[i]) push(1, pkt[i]);
        b0 = busy_cnt;
        foreach (pkt[i]) send_word(pkt[i]);
        drain(4);
        checks++; if (busy_cnt - b0 !== 3) begin errors++; $display("FAIL route_busy_cycles: got %0d want 3", busy_cnt - b0); end
        checks++; if (sb1.size() !== 0)    begin errors++; $display("FAIL route_delivered: %0d words missing, want 0", sb1.size()); end
        checks++; if (out_valid !== 3'b0)  begin errors++; $display("FAIL route_idle_valid: got %b want 000", out_valid); end
    endtask

    task automatic test_drop();
        int r0;
        r0 = rdy_low_cnt;
        send_word(32'h0000_000B);
        send_word(32'h2222_0001);
        send_word(32'h2222_0002);
        drain(2);
        checks++; if (rdy_low_cnt - r0 !== 0) begin errors++; $display("FAIL drop_ready: in_ready low %0d cycles, want 0", rdy_low_cnt - r0); end
        checks++; if (drop_cnt !== 8'd1)      begin errors++; $display("FAIL drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (out_valid !== 3'b0)     begin errors++; $display("FAIL drop_valid: got %b want 000", out_valid); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL drop_busy: got %b want 0", busy); end
    endtask

    task automatic test_backpressure();
        logic [31:0] w [9];
        w[0] = 32'h0000_0020;
        for (int i = 1; i < 9; i++) w[i] = 32'h3333_0000 + i;
        foreach (w[i]) push(0, w[i]);
        out_ready = 3'b110;
        for (int i = 0; i < 4; i++) send_word(w[i]);
        in_data  = w[4];
        in_valid = 1'b1;
        repeat (3) begin
            cycle();
            checks++; if (s_rdy !== 1'b0) begin errors++; $display("FAIL bp_ready_full: got %b want 0", s_rdy); end
        end
        checks++; if (s_valid[0] !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b want 1", s_valid[0]); end
        in_valid  = 1'b0;
        out_ready = 3'b111;
        for (int i = 4; i < 9; i++) send_word(w[i]);
        drain(6);
        checks++; if (sb0.size() !== 0) begin errors++; $display("FAIL bp_delivered: %0d words missing, want 0", sb0.size()); end
    endtask

    task automatic test_timeout();
        int n_stall;
        int pulses;
        int pulse_at;
        n_stall  = 0;
        pulses   = 0;
        pulse_at = 0;
        out_ready = 3'b011;
        send_word(32'h0000_0002);
        repeat (40) begin
            cycle();
            if (s_pulse[2]) begin
                pulses++;
                pulse_at = n_stall + 1;
            end
            if (s_valid[2]) n_stall++;
        end
        checks++; if (pulses !== 1)       begin errors++; $display("FAIL to_pulse_count: got %0d want 1", pulses); end
        checks++; if (pulse_at !== 30)    begin errors++; $display("FAIL to_pulse_cycle: got %0d want 30", pulse_at); end
        checks++; if (n_stall !== 30)     begin errors++; $display("FAIL to_valid_cycles: got %0d want 30", n_stall); end
        checks++; if (out_valid[2] !== 0) begin errors++; $display("FAIL to_flushed: got %b want 0", out_valid[2]); end
        out_ready = 3'b111;
    endtask

    task automatic test_midpkt_timeout();
        int r0;
        bit got;
        logic [31:0] w [11];
        w[0] = 32'h0000_0028;
        for (int i = 1; i < 11; i++) w[i] = 32'h5555_0000 + i;
        out_ready = 3'b111;
        for (int i = 0; i < 5; i++) push(0, w[i]);
        for (int i = 0; i < 5; i++) send_word(w[i]);
        drain(1);
        out_ready = 3'b110;
        send_word(w[5]);
        got = 1'b0;
        for (int i = 0; i < 60 && !got; i++) begin
            cycle();
            got = s_pulse[0];
        end
        checks++; if (got !== 1'b1) begin errors++; $display("FAIL mid_pulse: seen=%b want 1", got); end
        cycle();
        checks++; if (s_busy !== 1'b1)     begin errors++; $display("FAIL mid_drop_busy: got %b want 1", s_busy); end
        checks++; if (s_valid[0] !== 1'b0) begin errors++; $display("FAIL mid_flushed: got %b want 0", s_valid[0]); end
        r0 = rdy_low_cnt;
        for (int i = 6; i < 11; i++) send_word(w[i]);
        drain(2);
        checks++; if (rdy_low_cnt - r0 !== 0) begin errors++; $display("FAIL mid_drop_ready: low %0d cycles want 0", rdy_low_cnt - r0); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL mid_busy_end: got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'd1)      begin errors++; $display("FAIL mid_drop_cnt: got %0d want 1", drop_cnt); end
        checks++; if (out_valid !== 3'b0)     begin errors++; $display("FAIL mid_valid: got %b want 000", out_valid); end
        out_ready = 3'b111;
        push(1, 32'h0000_0005);
        push(1, 32'h6666_0001);
        send_word(32'h0000_0005);
        send_word(32'h6666_0001);
        drain(3);
        checks++; if (sb0.size() + sb1.size() !== 0) begin errors++; $display("FAIL mid_next_pkt: %0d words missing want 0", sb0.size() + sb1.size()); end
    endtask

    task automatic test_reset_mid();
        out_ready = 3'b000;
        send_word(32'h0000_0019);
        send_word(32'h7777_0001);
        send_word(32'h7777_0002);
        rst = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b0)      begin errors++; $display("FAIL rmid_in_ready: got %b want 0", in_ready); end
        checks++; if (out_valid !== 3'b0)     begin errors++; $display("FAIL rmid_out_valid: got %b want 000", out_valid); end
        checks++; if (out_data !== 96'd0)     begin errors++; $display("FAIL rmid_out_data: got %h want 0", out_data); end
        checks++; if (busy !== 1'b0)          begin errors++; $display("FAIL rmid_busy: got %b want 0", busy); end
        checks++; if (drop_cnt !== 8'd0)      begin errors++; $display("FAIL rmid_drop_cnt: got %0d want 0", drop_cnt); end
        checks++; if (timeout_pulse !== 3'b0) begin errors++; $display("FAIL rmid_pulse: got %b want 000", timeout_pulse); end
        drain(2);
        rst = 1'b0;
        out_ready = 3'b111;
        push(1, 32'h0000_0005);
        push(1, 32'h7777_00AA);
        send_word(32'h0000_0005);
        send_word(32'h7777_00AA);
        drain(3);
        checks++; if (sb1.size() !== 0) begin errors++; $display("FAIL rmid_next_pkt: %0d words missing want 0", sb1.size()); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL rmid_busy_end: got %b want 0", busy); end
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 3'b000;
        test_reset();
        test_route();
        test_drop();
        test_backpressure();
        test_timeout();
        test_midpkt_timeout();
        test_reset_mid();
        checks++;
        if (sb0.size() + sb1.size() + sb2.size() !== 0) begin
            errors++;
            $display("FAIL sb_leftover: %0d words never delivered, want 0", sb0.size() + sb1.size() + sb2.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
